// File: rtl/ram_sp_clr_if.sv
// Request/response bundle for the single-port scratch RAM with clear sequencing.
// The master drives read/write requests; the slave returns data, strobes and status.
interface ram_sp_clr_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              err;
  logic              busy;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, rd_valid, wr_ack, err, busy
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, rd_valid, wr_ack, err, busy
  );
endinterface

// File: rtl/ram_sp_clr.sv
// Parametrised scratch RAM that zeroes itself one word per cycle after reset.
// Define RAM_BYPASS_EN to forward same-address writes to the read port (write-first).
module ram_sp_clr #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 128
) (
  input logic         clk,
  input logic         reset,
  ram_sp_clr_if.slave bus
);
  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_addr_reg, clr_addr_next;

  logic clearing, running;
  logic rd_oob, wr_oob;
  logic mem_we;
  logic [IDX_W-1:0]  mem_waddr, rd_idx;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic [DATA_W-1:0] rd_data_reg;
  logic              rd_valid_reg, wr_ack_reg, err_reg;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= CLEAR;
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  // Next-state logic: clr_addr stops at the last word instead of wrapping
  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    case (state_reg)
      CLEAR: begin
        if (clr_addr_reg == CLR_LAST) state_next = RUN;
        else clr_addr_next = clr_addr_reg + 1'b1;
      end
      RUN:     state_next = RUN;
      default: state_next = CLEAR;
    endcase
  end

  // Output decode
  always_comb begin
    clearing = 1'b0;
    running  = 1'b0;
    case (state_reg)
      CLEAR:   clearing = 1'b1;
      RUN:     running  = 1'b1;
      default: clearing = 1'b1;
    endcase
  end

  assign rd_oob = {1'b0, bus.rd_addr} >= DEPTH_X;
  assign wr_oob = {1'b0, bus.wr_addr} >= DEPTH_X;
  assign rd_idx = IDX_W'(bus.rd_addr);

  // The clear sequence and user writes share one write port
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = IDX_W'(bus.wr_addr);
    mem_wdata = bus.wr_data;
    if (!reset) begin
      if (clearing) begin
        mem_we    = 1'b1;
        mem_waddr = IDX_W'(clr_addr_reg);
        mem_wdata = '0;
      end else if (bus.wr_en && !wr_oob) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

`ifdef RAM_BYPASS_EN
  logic wr_hit;
  assign wr_hit = bus.wr_en && (bus.wr_addr == bus.rd_addr);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_reg <= '0;
    end else if (running && bus.rd_en) begin
      if (rd_oob)
        rd_data_reg <= '0;
`ifdef RAM_BYPASS_EN
      else if (wr_hit)
        rd_data_reg <= bus.wr_data;
`endif
      else
        rd_data_reg <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_reg <= 1'b0;
      wr_ack_reg   <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      rd_valid_reg <= running && bus.rd_en;
      wr_ack_reg   <= running && bus.wr_en;
      err_reg      <= running && ((bus.rd_en && rd_oob) || (bus.wr_en && wr_oob));
    end
  end

  assign bus.rd_data  = rd_data_reg;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.wr_ack   = wr_ack_reg;
  assign bus.err      = err_reg;
  assign bus.busy     = clearing;
endmodule

// File: tb/tb_ram_sp_clr.sv
// Directed bench for ram_sp_clr (DEPTH=100): expectations are queued per driven cycle
// and checked 1 time unit after the following rising edge.
module tb_ram_sp_clr;
  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 100;

`ifdef RAM_BYPASS_EN
  localparam logic [7:0] COLLIDE_DATA = 8'h3C;
`else
  localparam logic [7:0] COLLIDE_DATA = 8'h11;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_sp_clr_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ram_sp_clr #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic       valid;
    logic       chk_data;
    logic [7:0] data;
    logic       ack;
    logic       err;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t ex(logic v, logic chk, logic [7:0] d, logic a, logic er, logic b);
    exp_t e;
    e.valid = v; e.chk_data = chk; e.data = d; e.ack = a; e.err = er; e.busy = b;
    return e;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("rd_valid", {7'd0, bus.rd_valid}, {7'd0, e.valid});
      check("wr_ack",   {7'd0, bus.wr_ack},   {7'd0, e.ack});
      check("err",      {7'd0, bus.err},      {7'd0, e.err});
      check("busy",     {7'd0, bus.busy},     {7'd0, e.busy});
      if (e.chk_data) check("rd_data", bus.rd_data, e.data);
      $display("t=%0t valid=%0b data=0x%02h ack=%0b err=%0b busy=%0b", $time,
               bus.rd_valid, bus.rd_data, bus.wr_ack, bus.err, bus.busy);
    end
  end

  task automatic step(input logic rst, input logic re, input logic [7:0] ra,
                      input logic we, input logic [7:0] wa, input logic [7:0] wd,
                      input exp_t e);
    @(negedge clk);
    reset       = rst;
    bus.rd_en   = re;
    bus.rd_addr = ra;
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    sb.push_back(e);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] d, input logic er);
    step(1'b0, 1'b1, a, 1'b0, 8'h00, 8'h00, ex(1'b1, 1'b1, d, 1'b0, er, 1'b0));
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic er);
    step(1'b0, 1'b0, 8'h00, 1'b1, a, d, ex(1'b0, 1'b0, 8'h00, 1'b1, er, 1'b0));
  endtask

  // Reset-release clear: busy holds until the DEPTH-th edge, rd_en held high throughout
  task automatic clear_run(input logic [7:0] ra);
    for (int k = 1; k <= DEPTH; k++)
      step(1'b0, 1'b1, ra, (k == 5), 8'd2, 8'h77,
           ex(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, (k < DEPTH)));
  endtask

  initial begin
    reset       = 1'b1;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;

    repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00,
                    ex(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1));
    clear_run(8'd5);

    for (int i = 0; i < DEPTH; i++) rd(8'(i), 8'h00, 1'b0);

    wr(8'd3, 8'hA5, 1'b0);
    rd(8'd3, 8'hA5, 1'b0);
    // rd_data holds after the read completes
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, ex(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0));

    wr(8'd7, 8'h11, 1'b0);
    step(1'b0, 1'b1, 8'd7, 1'b1, 8'd7, 8'h3C, ex(1'b1, 1'b1, COLLIDE_DATA, 1'b1, 1'b0, 1'b0));
    rd(8'd7, 8'h3C, 1'b0);

    wr(8'd99, 8'h99, 1'b0);
    rd(8'd99, 8'h99, 1'b0);
    wr(8'd100, 8'hFF, 1'b1);
    rd(8'd100, 8'h00, 1'b1);
    rd(8'd99, 8'h99, 1'b0);
    wr(8'd255, 8'h12, 1'b1);
    rd(8'd255, 8'h00, 1'b1);

    // Out-of-range read alongside an in-range write
    step(1'b0, 1'b1, 8'd100, 1'b1, 8'd10, 8'h42, ex(1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0));
    rd(8'd10, 8'h42, 1'b0);

    for (int i = 0; i < 4; i++) wr(8'(20 + i), 8'(8'h20 + 3 * i), 1'b0);
    for (int i = 0; i < 4; i++) rd(8'(20 + i), 8'(8'h20 + 3 * i), 1'b0);

    wr(8'd1, 8'h55, 1'b0);
    rd(8'd1, 8'h55, 1'b0);
    step(1'b1, 1'b1, 8'd1, 1'b0, 8'h00, 8'h00, ex(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1));
    clear_run(8'd1);
    rd(8'd1, 8'h00, 1'b0);
    rd(8'd2, 8'h00, 1'b0);
    rd(8'd3, 8'h00, 1'b0);

    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, ex(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #2;
    check("drain", 8'(sb.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
